// File: rtl/serial_digit_adder_pkg.sv
// Shared types and parameter derivations for the digit-serial add/subtract unit.
// The FSM state encoding and step-count helpers live here so every file agrees on them.
package serial_digit_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nsteps(input int width, input int digit);
      return width / digit;
   endfunction

   // Counter must be at least one bit wide even when a single step covers the operand.
   function automatic int cnt_w(input int width, input int digit);
      return ((width / digit) > 32'sd1) ? $clog2(width / digit) : 32'sd1;
   endfunction

   function automatic bit digit_ok(input int width, input int digit);
      return (digit >= 32'sd1) && (digit <= width) && ((width % digit) == 32'sd0);
   endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Request/response bundle of the digit-serial adder: operands and start in,
// status and registered result out.
interface serial_digit_adder_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/serial_digit_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder made of full-adder cells; also exposes the
// carry into its top bit so the caller can form two's-complement overflow.
module digit_adder #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c_s;

   assign c_s[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]     = x[i] ^ y[i] ^ c_s[i];
      assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
   end

   assign co    = c_s[DIGIT];
   assign c_msb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract: operands are captured on start, DIGIT bits are summed
// per clock through a registered carry, and a one-cycle done pulse flags the result.
module serial_digit_adder
   import serial_digit_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input logic                clk,
   input logic                rst,
   serial_digit_adder_if.slave bus
);

   localparam int NSTEPS = nsteps(WIDTH, DIGIT);
   localparam int CW     = cnt_w(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);
   localparam logic [CW-1:0] STEP_ONE  = CW'(1);

   if (!digit_ok(WIDTH, DIGIT)) begin : g_param_check
      $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
   end

   state_t            state_r;
   state_t            state_s;
   logic              accept_s;
   logic              last_s;
   logic [CW-1:0]     step_r;
   logic [WIDTH-1:0]  opa_r;
   logic [WIDTH-1:0]  opb_r;
   logic              carry_r;
   logic [WIDTH-1:0]  sum_r;
   logic              cout_r;
   logic              ovf_r;
   logic              busy_r;
   logic              done_r;
   logic [DIGIT-1:0]  dsum_s;
   logic              dco_s;
   logic              dcmsb_s;
   logic [WIDTH+DIGIT-1:0] sum_cat_s;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .x     (opa_r[DIGIT-1:0]),
      .y     (opb_r[DIGIT-1:0]),
      .ci    (carry_r),
      .s     (dsum_s),
      .co    (dco_s),
      .c_msb (dcmsb_s)
   );

   // New digit enters at the MSB end; after NSTEPS shifts the full sum is aligned.
   assign sum_cat_s = {dsum_s, sum_r};

   // Next-state and step strobes; start is only honoured outside RUN.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      last_s   = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (bus.start) begin
               state_s  = RUN;
               accept_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (step_r == LAST_STEP) begin
               state_s = DONE;
               last_s  = 1'b1;
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture, per-digit shifting, carry chain and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_r  <= '0;
         opa_r   <= '0;
         opb_r   <= '0;
         carry_r <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         busy_r <= (state_s == RUN);
         done_r <= (state_s == DONE);
         if (accept_s) begin
            opa_r   <= bus.a;
            opb_r   <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.cin ^ bus.sub;
            step_r  <= '0;
         end else if (state_r == RUN) begin
            opa_r   <= opa_r >> DIGIT;
            opb_r   <= opb_r >> DIGIT;
            carry_r <= dco_s;
            step_r  <= step_r + STEP_ONE;
            sum_r   <= sum_cat_s[WIDTH+DIGIT-1:DIGIT];
            if (last_s) begin
               cout_r <= dco_s;
               ovf_r  <= dcmsb_s ^ dco_s;
            end
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder: directed vectors on a DIGIT=8 instance
// plus random sweeps on DIGIT 1/4/32 instances checked against a reference model.
module tb_serial_digit_adder;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           k;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   exp_t me;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_digit_adder_if #(.WIDTH(W)) bus ();
   serial_digit_adder #(.WIDTH(W), .DIGIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Independent model: wide arithmetic, borrow-style cout for subtraction.
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub, input logic cin);
      logic [W:0] r;
      logic       c;
      logic       o;
      if (!sub) begin
         r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         c = r[W];
         o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end else begin
         r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
         c = ~r[W];
         o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      return {o, c, r[W-1:0]};
   endfunction

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            me = q.pop_front();
            chk("sum", 64'(bus.sum), 64'(me.sum));
            chk("cout", 64'(bus.cout), 64'(me.cout));
            chk("ovf", 64'(bus.ovf), 64'(me.ovf));
            chk("latency", 64'(cyc - me.k), 64'd4);
         end
      end
   end

   // Caller is at a negedge; returns at the negedge after the start edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
      bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.start = 1'b1;
      @(posedge clk);
      #1;
      q.push_back('{es, ec, eo, cyc});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({"done_seen_", name}, 64'(n < 100), 64'd1);
      @(negedge clk);
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int DG = (gi == 0) ? 1 : ((gi == 1) ? 4 : 32);
      logic srst;
      bit   fin = 1'b0;
      exp_t sq[$];
      exp_t se;

      serial_digit_adder_if #(.WIDTH(W)) sbus ();
      serial_digit_adder #(.WIDTH(W), .DIGIT(DG)) sdut (.clk(clk), .rst(srst), .bus(sbus));

      always @(negedge clk) begin
         if (sbus.done === 1'b1) begin
            if (sq.size() == 0) begin
               chk($sformatf("sweep%0d_unexpected_done", DG), 64'd1, 64'd0);
            end else begin
               se = sq.pop_front();
               chk($sformatf("sweep%0d_sum", DG), 64'(sbus.sum), 64'(se.sum));
               chk($sformatf("sweep%0d_cout", DG), 64'(sbus.cout), 64'(se.cout));
               chk($sformatf("sweep%0d_ovf", DG), 64'(sbus.ovf), 64'(se.ovf));
               chk($sformatf("sweep%0d_latency", DG), 64'(cyc - se.k), 64'(W / DG));
            end
         end
      end

      initial begin
         logic [W-1:0] ra, rb;
         logic         rs, rc;
         logic [W+1:0] ex;
         int           n;
         srst = 1'b1;
         sbus.start = 1'b0; sbus.a = '0; sbus.b = '0; sbus.sub = 1'b0; sbus.cin = 1'b0;
         repeat (3) @(negedge clk);
         srst = 1'b0;
         for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ex = ref_model(ra, rb, rs, rc);
            sbus.a = ra; sbus.b = rb; sbus.sub = rs; sbus.cin = rc; sbus.start = 1'b1;
            @(posedge clk);
            #1;
            sq.push_back('{ex[W-1:0], ex[W], ex[W+1], cyc});
            @(negedge clk);
            sbus.start = 1'b0;
            n = 0;
            while (sbus.done !== 1'b1 && n < 200) begin
               @(negedge clk);
               n++;
            end
            chk($sformatf("sweep%0d_done_seen", DG), 64'(n < 200), 64'd1);
            @(negedge clk);
         end
         fin = 1'b1;
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_sum", 64'(bus.sum), 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      wait_done("add_wrap");
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      wait_done("signed_ovf");
      issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      wait_done("sub_borrow");
      issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
      wait_done("sub_cin");

      // start re-pulsed mid-RUN must not disturb the operation in flight
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_0001; bus.sub = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ignore_start");

      // back-to-back: second start lands in the DONE cycle
      issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_done", 64'(n < 100), 64'd1);
      issue(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_000D, 1'b1, 1'b0);
      chk("b2b_busy", 64'(bus.busy), 64'd1);
      wait_done("b2b_second");

      // reset during digit 2 discards the operation
      issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_done", 64'(bus.done), 64'd0);
      chk("midrst_sum", 64'(bus.sum), 64'd0);
      chk("midrst_cout", 64'(bus.cout), 64'd0);
      chk("midrst_ovf", 64'(bus.ovf), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      void'(q.pop_back());
      repeat (10) @(negedge clk);
      issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0);
      wait_done("after_rst");
      chk("queue_empty", 64'(q.size()), 64'd0);

      n = 0;
      while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && n < 60000) begin
         @(negedge clk);
         n++;
      end
      chk("sweep_finished", 64'(n < 60000), 64'd1);
      chk("sweep_queues_empty", 64'(g_sw[0].sq.size() + g_sw[1].sq.size() + g_sw[2].sq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
